fetch_stage: RTL and testbench

- Instruction-fetch stage of the Lab5 pipelined core inside `top`; sits directly upstream of decode and feeds the IF/ID pipeline register.
- Holds the PC and drives a synchronous-read instruction memory (1-cycle read latency).
- Handles decode stall, EX-stage branch redirect and HALT detection.
- Counts delivered instructions for the bench.

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bundle: redirect/stall controls, instruction memory port and IF/ID outputs.
interface fetch_if #(
  parameter int ADDR_W  = 9,
  parameter int INSTR_W = 32
);
  logic               stall_i;
  logic               branch_taken_i;
  logic [ADDR_W-1:0]  branch_target_i;
  logic [ADDR_W-1:0]  imem_addr_o;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic [INSTR_W-1:0] ifid_instr_o;
  logic [ADDR_W-1:0]  ifid_pc_o;
  logic               ifid_valid_o;
  logic               halt_o;
  logic [31:0]        fetch_count_o;

  modport slave (
    input  stall_i, branch_taken_i, branch_target_i, imem_rdata_i,
    output imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, halt_o, fetch_count_o
  );

  modport master (
    output stall_i, branch_taken_i, branch_target_i, imem_rdata_i,
    input  imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, halt_o, fetch_count_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, sync-read imem with one in-flight slot, stall replay,
// branch redirect, HALT detection and a saturating delivered-instruction counter.
module fetch_stage #(
  parameter int                 ADDR_W     = 9,
  parameter int                 INSTR_W    = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = '1
) (
  input logic     clk,
  input logic     rst,
  fetch_if.slave  bus
);
  typedef enum logic {RUN, HALTED} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic               inflight_valid_q, inflight_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [31:0]        fetch_count_q, fetch_count_d;
  logic               capture;
  logic               halt_hit;

  // An IF/ID load that takes real memory data this edge.
  assign capture  = !bus.branch_taken_i && !bus.stall_i && (state_q == RUN) && inflight_valid_q;
  assign halt_hit = capture && (bus.imem_rdata_i == HALT_INSTR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      pc_q             <= '0;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
      ifid_instr_q     <= NOP_INSTR;
      ifid_pc_q        <= '0;
      ifid_valid_q     <= 1'b0;
      fetch_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
      ifid_instr_q     <= ifid_instr_d;
      ifid_pc_q        <= ifid_pc_d;
      ifid_valid_q     <= ifid_valid_d;
      fetch_count_q    <= fetch_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.branch_taken_i) state_d = RUN;
    else if (halt_hit)      state_d = HALTED;
  end

  always_comb begin
    pc_d             = pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = inflight_valid_q;
    ifid_instr_d     = ifid_instr_q;
    ifid_pc_d        = ifid_pc_q;
    ifid_valid_d     = ifid_valid_q;
    fetch_count_d    = fetch_count_q;

    // While stalled the memory must re-present the held in-flight word.
    bus.imem_addr_o = (bus.stall_i && state_q == RUN) ? inflight_pc_q : pc_q;

    if (bus.branch_taken_i) begin
      pc_d             = bus.branch_target_i;
      inflight_valid_d = 1'b0;
      ifid_instr_d     = NOP_INSTR;
      ifid_valid_d     = 1'b0;
    end else if (!bus.stall_i) begin
      if (state_q == RUN) begin
        ifid_instr_d = inflight_valid_q ? bus.imem_rdata_i : NOP_INSTR;
        ifid_pc_d    = inflight_pc_q;
        ifid_valid_d = inflight_valid_q;
        if (halt_hit) begin
          inflight_valid_d = 1'b0;
        end else begin
          inflight_pc_d    = pc_q;
          inflight_valid_d = 1'b1;
          pc_d             = pc_q + ADDR_W'(1);
        end
      end else begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
    end

    if (capture && fetch_count_q != 32'hFFFF_FFFF)
      fetch_count_d = fetch_count_q + 32'd1;
  end

  assign bus.ifid_instr_o  = ifid_instr_q;
  assign bus.ifid_pc_o     = ifid_pc_q;
  assign bus.ifid_valid_o  = ifid_valid_q;
  assign bus.halt_o        = (state_q == HALTED);
  assign bus.fetch_count_o = fetch_count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID loads go into a scoreboard
// queue; a negedge monitor pops and compares each fresh valid load.
module tb_fetch_stage;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    logic [8:0]  pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] mem [512];
  exp_t        sbq[$];
  exp_t        last_ld;
  logic        e_rst, e_stall, e_br;
  int          n_tests, n_fail;

  fetch_if #(.ADDR_W(9), .INSTR_W(32)) bus ();
  fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) bus.imem_rdata_i <= mem[bus.imem_addr_o];

  always @(posedge clk) begin
    e_rst   <= rst;
    e_stall <= bus.stall_i;
    e_br    <= bus.branch_taken_i;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a held IF/ID during stall must match the last load; otherwise a valid output is a new load.
  always @(negedge clk) begin
    if (e_rst === 1'b0 && bus.ifid_valid_o === 1'b1) begin
      if (e_stall && !e_br) begin
        chk("hold_pc", 64'(bus.ifid_pc_o), 64'(last_ld.pc));
        chk("hold_instr", 64'(bus.ifid_instr_o), 64'(last_ld.instr));
      end else if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_load: got pc %0h instr %0h, expected no load", bus.ifid_pc_o, bus.ifid_instr_o);
      end else begin
        last_ld = sbq.pop_front();
        chk("sb_pc", 64'(bus.ifid_pc_o), 64'(last_ld.pc));
        chk("sb_instr", 64'(bus.ifid_instr_o), 64'(last_ld.instr));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [8:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    sbq.push_back(e);
  endtask

  // Memory word[i] = i+1, so a plain fetch of pc expects pc+1.
  task automatic push_seq(input int start, input int n);
    for (int i = 0; i < n; i++) push(9'(start + i), 32'(start + i + 1));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 64'(bus.ifid_valid_o), 64'd0);
    chk({tag, "_instr"}, 64'(bus.ifid_instr_o), 64'd0);
    chk({tag, "_pc"}, 64'(bus.ifid_pc_o), 64'd0);
    chk({tag, "_halt"}, 64'(bus.halt_o), 64'd0);
    chk({tag, "_count"}, 64'(bus.fetch_count_o), 64'd0);
    chk({tag, "_addr"}, 64'(bus.imem_addr_o), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step(2);
    chk_reset(tag);
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.branch_target_i = '0;
    for (int i = 0; i < 512; i++) mem[i] = 32'(i + 1);

    // Sequential run with a 3-cycle stall while pc 4 is held.
    do_reset("rst0");
    push_seq(0, 10);
    step(1);
    chk("first_bubble", 64'(bus.ifid_valid_o), 64'd0);
    step(1);
    chk("first_valid", 64'(bus.ifid_valid_o), 64'd1);
    step(4);
    chk("pre_stall_pc", 64'(bus.ifid_pc_o), 64'd4);
    bus.stall_i = 1'b1;
    #1;
    chk("replay_addr", 64'(bus.imem_addr_o), 64'd5);
    step(3);
    chk("stall_pc", 64'(bus.ifid_pc_o), 64'd4);
    chk("stall_count", 64'(bus.fetch_count_o), 64'd5);
    bus.stall_i = 1'b0;
    step(5);
    chk("count10", 64'(bus.fetch_count_o), 64'd10);

    // Branch at pc_q=8, then branch+stall to 0x1FE with wrap, then mid-stream reset.
    do_reset("rst1");
    push_seq(0, 7);
    step(8);
    chk("pre_br_pc", 64'(bus.ifid_pc_o), 64'd6);
    chk("pre_br_addr", 64'(bus.imem_addr_o), 64'd8);
    bus.branch_taken_i = 1'b1;
    bus.branch_target_i = 9'h040;
    step(1);
    chk("br_bubble1", 64'(bus.ifid_valid_o), 64'd0);
    bus.branch_taken_i = 1'b0;
    step(1);
    chk("br_bubble2", 64'(bus.ifid_valid_o), 64'd0);
    push_seq(9'h040, 2);
    step(2);
    chk("br_tgt_pc", 64'(bus.ifid_pc_o), 64'h41);
    bus.branch_taken_i = 1'b1;
    bus.stall_i = 1'b1;
    bus.branch_target_i = 9'h1FE;
    step(1);
    chk("brst_bubble1", 64'(bus.ifid_valid_o), 64'd0);
    bus.branch_taken_i = 1'b0;
    bus.stall_i = 1'b0;
    step(1);
    chk("brst_bubble2", 64'(bus.ifid_valid_o), 64'd0);
    push(9'h1FE, 32'h1FF);
    push(9'h1FF, 32'h200);
    push(9'h000, 32'h1);
    step(3);
    chk("wrap_pc", 64'(bus.ifid_pc_o), 64'd0);
    chk("wrap_valid", 64'(bus.ifid_valid_o), 64'd1);
    rst = 1'b1;
    step(1);
    chk_reset("rst_mid");
    rst = 1'b0;
    push_seq(0, 1);
    step(2);
    chk("restart_pc", 64'(bus.ifid_pc_o), 64'd0);
    chk("restart_count", 64'(bus.fetch_count_o), 64'd1);

    // HALT at word 6, bubbles while halted (one edge stalled), then branch to 0 recovers.
    mem[6] = HALT;
    do_reset("rst2");
    push_seq(0, 6);
    push(9'd6, HALT);
    step(8);
    chk("halt_instr", 64'(bus.ifid_instr_o), 64'(HALT));
    chk("halt_flag", 64'(bus.halt_o), 64'd1);
    chk("halt_addr", 64'(bus.imem_addr_o), 64'd7);
    chk("halt_count", 64'(bus.fetch_count_o), 64'd7);
    step(1);
    chk("halted_bubble", 64'(bus.ifid_valid_o), 64'd0);
    bus.stall_i = 1'b1;
    step(1);
    chk("halted_stall", 64'(bus.ifid_valid_o), 64'd0);
    bus.stall_i = 1'b0;
    step(1);
    chk("halted_addr", 64'(bus.imem_addr_o), 64'd7);
    chk("halted_count", 64'(bus.fetch_count_o), 64'd7);
    bus.branch_taken_i = 1'b1;
    bus.branch_target_i = 9'h000;
    step(1);
    chk("unhalt", 64'(bus.halt_o), 64'd0);
    chk("unhalt_bubble1", 64'(bus.ifid_valid_o), 64'd0);
    bus.branch_taken_i = 1'b0;
    step(1);
    chk("unhalt_bubble2", 64'(bus.ifid_valid_o), 64'd0);
    push_seq(0, 2);
    step(2);
    chk("unhalt_pc", 64'(bus.ifid_pc_o), 64'd1);
    @(negedge clk);
    #1;
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
